// File: rtl/mac_accumulator.sv
// mac_accumulator: two-stage pipelined signed multiply-accumulate for one
// dot product per vector. Stage 1 registers the exact 2*BIT_WIDTH product.
// Stage 2 accumulates the products and emits one result per vector, marked
// by in_last.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   in_a, in_b         signed operands (Q format with FRAC_WIDTH fraction bits)
//   in_valid, in_last  operand pair valid / final pair of the vector
//   in_ready           pair accepted this cycle when in_valid is also high
//   out_data           signed accumulated dot product, 2*FRAC_WIDTH fraction bits
//   out_count          number of pairs in the emitted vector (wraps)
//   out_valid          out_data/out_count valid, held until out_ready
//   out_ready          downstream accepts the result
//
// Optional macro ACC_SAT_EN: when defined, each accumulate add saturates to
// the signed 2*BIT_WIDTH range. When it is undefined, the add wraps.
module mac_accumulator #(
  parameter int BIT_WIDTH  = 16,
  parameter int FRAC_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [BIT_WIDTH-1:0]   in_a,
  input  logic [BIT_WIDTH-1:0]   in_b,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic [2*BIT_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]   out_count,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int W2 = 2 * BIT_WIDTH;

  if (FRAC_WIDTH >= BIT_WIDTH) begin : g_bad_frac
    $error("FRAC_WIDTH must be smaller than BIT_WIDTH");
  end

  logic                 en;
  logic signed [W2-1:0] p;
  logic                 p_valid;
  logic                 p_last;
  logic signed [W2-1:0] acc;
  logic signed [W2-1:0] add;
  logic signed [W2-1:0] sum;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic                 first;

  // The whole pipeline advances only when the output register is free or
  // is being drained in this cycle.
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

`ifdef ACC_SAT_EN
  logic [W2:0] wide_sum;

  // A sign-extended add exposes overflow as a mismatch of the top two bits.
  always_comb begin
    wide_sum = {acc[W2-1], acc} + {p[W2-1], p};
    if (wide_sum[W2] != wide_sum[W2-1]) begin
      add = wide_sum[W2] ? {1'b1, {(W2-1){1'b0}}} : {1'b0, {(W2-1){1'b1}}};
    end else begin
      add = wide_sum[W2-1:0];
    end
  end
`else
  assign add = acc + p;
`endif

  assign sum      = first ? p : add;
  assign cnt_next = first ? CNT_WIDTH'(1) : cnt + CNT_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      p         <= '0;
      p_valid   <= 1'b0;
      p_last    <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      first     <= 1'b1;
      out_data  <= '0;
      out_count <= '0;
      out_valid <= 1'b0;
    end else if (en) begin
      // Sign-extending both operands before the multiply makes the product exact.
      p       <= W2'($signed(in_a)) * W2'($signed(in_b));
      p_valid <= in_valid;
      p_last  <= in_last;

      if (p_valid) begin
        if (p_last) begin
          out_data  <= sum;
          out_count <= cnt_next;
          out_valid <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
          first     <= 1'b1;
        end else begin
          acc   <= sum;
          cnt   <= cnt_next;
          first <= 1'b0;
        end
      end

      if (!(p_valid && p_last) && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Self-checking bench for mac_accumulator: directed scenarios followed by a
// randomized stream checked against a queue-based reference model.
module tb_mac_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [31:0] out_data;
  logic [7:0]  out_count;
  logic        out_valid;
  logic        out_ready;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  longint exp_sum_q[$];
  int     exp_cnt_q[$];

  mac_accumulator #(.BIT_WIDTH(16), .FRAC_WIDTH(8), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .out_data(out_data),
    .out_count(out_count), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b, input logic l);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_last  = l;
  endtask

  // Reference arithmetic: 32-bit signed accumulation, wrapping or clamping.
  function automatic longint acc_add(input longint x, input longint y);
    longint s;
    logic [31:0] lo;
    s = x + y;
`ifdef ACC_SAT_EN
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
`else
    lo = s[31:0];
    s  = longint'($signed(lo));
`endif
    return s;
  endfunction

  function automatic longint prod(input logic [15:0] a, input logic [15:0] b);
    return longint'($signed(a)) * longint'($signed(b));
  endfunction

  initial begin
    longint      m_sum;
    int          m_cnt;
    logic        hold_pend;
    logic [31:0] hold_data;
    logic [7:0]  hold_count;
    longint      e_sum;
    int          e_cnt;

    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, '0, '0, 1'b0);

    // 1. Reset / idle
    tick(); tick();
    rst = 1'b0;
    tick();
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_data",  64'(out_data),  64'd0);
    check("reset_out_count", 64'(out_count), 64'd0);
    check("reset_in_ready",  64'(in_ready),  64'd1);

    // 2. Three-element vector, result visible in cycle 4 only
    drive(1'b1, 16'h0180, 16'h0200, 1'b0); tick();
    drive(1'b1, 16'hFF00, 16'h0080, 1'b0); tick();
    drive(1'b1, 16'h0040, 16'h0400, 1'b1); tick();
    drive(1'b0, '0, '0, 1'b0);
    check("vec3_c3_valid", 64'(out_valid), 64'd0);
    tick();
    check("vec3_c4_valid", 64'(out_valid), 64'd1);
    check("vec3_data",     64'(out_data),  64'h0003_8000);
    check("vec3_count",    64'(out_count), 64'd3);
    tick();
    check("vec3_c5_valid", 64'(out_valid), 64'd0);

    // 3. Backpressure: result held, stray pairs refused, then handshake + accept
    out_ready = 1'b0;
    drive(1'b1, 16'h0180, 16'h0200, 1'b1); tick();
    drive(1'b0, '0, '0, 1'b0); tick();
    drive(1'b1, 16'h7FFF, 16'h7FFF, 1'b1);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_in_ready", 64'(in_ready),  64'd0);
      check("bp_valid",    64'(out_valid), 64'd1);
      check("bp_data",     64'(out_data),  64'h0003_0000);
      tick();
    end
    out_ready = 1'b1;
    drive(1'b1, 16'h0100, 16'h0100, 1'b1);
    #1;
    check("bp_release_ready", 64'(in_ready), 64'd1);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    check("bp_after_hs_valid", 64'(out_valid), 64'd0);
    tick();
    check("bp_next_valid", 64'(out_valid), 64'd1);
    check("bp_next_data",  64'(out_data),  64'h0001_0000);
    check("bp_next_count", 64'(out_count), 64'd1);
    tick();

    // 4. Single-element vectors streamed back to back
    for (int i = 0; i < 6; i++) begin
      drive(i < 4, 16'h0100, 16'h0100, 1'b1);
      tick();
      if (i + 1 >= 2) begin
        check("single_valid", 64'(out_valid), 64'((i + 1) <= 5));
        if (out_valid) begin
          check("single_data",  64'(out_data),  64'h0001_0000);
          check("single_count", 64'(out_count), 64'd1);
        end
      end
    end

    // 5. Overflow behaviour
    drive(1'b1, 16'h7FFF, 16'h7FFF, 1'b0); tick();
    drive(1'b1, 16'h7FFF, 16'h7FFF, 1'b0); tick();
    drive(1'b1, 16'h7FFF, 16'h7FFF, 1'b1); tick();
    drive(1'b0, '0, '0, 1'b0); tick();
    check("ovf_valid", 64'(out_valid), 64'd1);
`ifdef ACC_SAT_EN
    check("ovf_data", 64'(out_data), 64'h7FFF_FFFF);
`else
    check("ovf_data", 64'(out_data), 64'hBFFD_0003);
`endif
    check("ovf_count", 64'(out_count), 64'd3);
    tick();

    // 6. Mid-vector reset discards the partial sum
    drive(1'b1, 16'h0100, 16'h0100, 1'b0); tick();
    drive(1'b1, 16'h0100, 16'h0100, 1'b0); tick();
    drive(1'b0, '0, '0, 1'b0);
    rst = 1'b1; tick();
    rst = 1'b0;
    check("midrst_valid0", 64'(out_valid), 64'd0);
    drive(1'b1, 16'h0200, 16'h0200, 1'b1); tick();
    drive(1'b0, '0, '0, 1'b0); tick();
    check("midrst_valid", 64'(out_valid), 64'd1);
    check("midrst_data",  64'(out_data),  64'h0004_0000);
    check("midrst_count", 64'(out_count), 64'd1);
    tick(); tick();

    // Randomized stream against the queue model
    m_sum = 0;
    m_cnt = 0;
    hold_pend = 1'b0;
    hold_data = '0;
    hold_count = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic drain;
      drain = (cyc >= 2980);
      out_ready = drain ? 1'b1 : ($urandom_range(3, 0) != 0);
      if (drain)
        drive(1'b0, '0, '0, 1'b0);
      else
        drive($urandom_range(3, 0) != 0, 16'($urandom), 16'($urandom),
              $urandom_range(3, 0) == 0);
      #1;
      check("rnd_in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
      if (hold_pend) begin
        check("rnd_hold_valid", 64'(out_valid), 64'd1);
        check("rnd_hold_data",  64'(out_data),  64'(hold_data));
        check("rnd_hold_count", 64'(out_count), 64'(hold_count));
      end
      hold_pend  = out_valid && !out_ready;
      hold_data  = out_data;
      hold_count = out_count;
      if (out_valid && out_ready) begin
        if (exp_sum_q.size() == 0) begin
          check("rnd_unexpected_result", 64'd1, 64'd0);
        end else begin
          e_sum = exp_sum_q.pop_front();
          e_cnt = exp_cnt_q.pop_front();
          check("rnd_data",  64'(out_data),  64'(e_sum[31:0]));
          check("rnd_count", 64'(out_count), 64'(e_cnt % 256));
        end
      end
      if (in_valid && in_ready) begin
        m_sum = acc_add(m_sum, prod(in_a, in_b));
        m_cnt++;
        if (in_last) begin
          exp_sum_q.push_back(m_sum);
          exp_cnt_q.push_back(m_cnt);
          m_sum = 0;
          m_cnt = 0;
        end
      end
      tick();
    end
    check("rnd_results_drained", 64'(exp_sum_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
